fpcmp_share_sched: RTL

Round-robin scheduler that shares one pipelined floating-point greater-or-equal comparator among NREQ requesters in the Ray-AABB slab-test datapath. It accepts operand pairs over valid/ready handshakes and issues at most one pair per cycle to the comparator. A tag pipeline matching the comparator latency routes each result back to its requester. A drain/idle pair lets the top-level controller quiesce the comparator between rays.

---
 rtl/fpcmp_pkg.sv | 36 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/fpcmp_share_sched.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fpcmp_pkg.sv
// fpcmp_pkg: shared types and field helpers for the slab-test comparator scheduler.
// Optional feature macro: FPCMP_SCHED_NAN_EN (adds a nan bit to the tag).
package fpcmp_pkg;

  // Exception field encodings of the custom float format
  typedef enum logic [1:0] {
    EXC_ZERO   = 2'b00,
    EXC_NORMAL = 2'b01,
    EXC_INF    = 2'b10,
    EXC_NAN    = 2'b11
  } exc_e;

  // Tag id is sized for the largest supported requester count (8)
  localparam int unsigned TAG_IDW = 3;

  function automatic int unsigned exc_msb(input int unsigned width);
    return width;
  endfunction

  function automatic int unsigned exc_lsb(input int unsigned width);
    return width - 1;
  endfunction

  function automatic int unsigned sign_pos(input int unsigned width);
    return width - 2;
  endfunction

  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
`ifdef FPCMP_SCHED_NAN_EN
    logic               nan;
`endif
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching upward from ptr modulo NREQ.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  logic        found;
  int unsigned pos;

  // First requester at or after ptr wins; nothing is granted while disabled
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = (32'(ptr) + k) % NREQ;
      if (en && !found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = IDW'(pos);
      end
    end
  end

endmodule

// File: rtl/fpcmp_share_sched.sv
// fpcmp_share_sched: shares one pipelined FP >= comparator among NREQ requesters.
// Optional feature macro: FPCMP_SCHED_NAN_EN (resp_nan port, NaN forces resp_ge=0).
module fpcmp_share_sched
  import fpcmp_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 23,
  parameter int unsigned CMP_LAT = 3,
  parameter int unsigned IDW     = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*(WIDTH+1)-1:0] req_a,
  input  logic [NREQ*(WIDTH+1)-1:0] req_b,
  input  logic                      drain,
  output logic                      idle,
  output logic [WIDTH:0]            cmp_a,
  output logic [WIDTH:0]            cmp_b,
  input  logic                      cmp_ge,
  output logic [NREQ-1:0]           resp_valid,
  output logic [IDW-1:0]            resp_id,
  output logic                      resp_ge
`ifdef FPCMP_SCHED_NAN_EN
 ,output logic                      resp_nan
`endif
);

  localparam int unsigned OPW = WIDTH + 1;
`ifdef FPCMP_SCHED_NAN_EN
  localparam int unsigned EXC_MSB = exc_msb(WIDTH);
`endif

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            accept;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [WIDTH:0]  sel_a, sel_b;
  logic [WIDTH:0]  cmp_a_q, cmp_a_d, cmp_b_q, cmp_b_d;
  tag_t            tag_d;
  tag_t            tag_q [CMP_LAT+1];
  tag_t            tail;
  logic [NREQ-1:0] resp_valid_q, resp_valid_d;
  logic [IDW-1:0]  resp_id_q, resp_id_d;
  logic            resp_ge_q, resp_ge_d;
  logic            busy;
`ifdef FPCMP_SCHED_NAN_EN
  logic            resp_nan_q, resp_nan_d;
`endif

  // Gating en with rst keeps req_ready low throughout reset
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req (req_valid),
    .en  (~drain & rst),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign accept    = |(req_valid & gnt);
  assign tail      = tag_q[CMP_LAT];

  // Mux the granted requester's operand pair
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_a = req_a[i*OPW +: OPW];
        sel_b = req_b[i*OPW +: OPW];
      end
    end
  end

  // Issue: capture operands, launch a tag and advance the pointer on accept
  always_comb begin
    cmp_a_d = cmp_a_q;
    cmp_b_d = cmp_b_q;
    ptr_d   = ptr_q;
    tag_d   = '0;
    if (accept) begin
      cmp_a_d     = sel_a;
      cmp_b_d     = sel_b;
      tag_d.valid = 1'b1;
      tag_d.id    = TAG_IDW'(gnt_idx);
`ifdef FPCMP_SCHED_NAN_EN
      tag_d.nan   = (sel_a[EXC_MSB -: 2] == EXC_NAN) || (sel_b[EXC_MSB -: 2] == EXC_NAN);
`endif
      ptr_d       = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
    end
  end

  // Result register loads from the tail tag alongside the comparator output
  always_comb begin
    resp_valid_d = tail.valid ? (NREQ'(1) << tail.id) : '0;
    resp_id_d    = IDW'(tail.id);
`ifdef FPCMP_SCHED_NAN_EN
    resp_ge_d    = cmp_ge & ~tail.nan;
    resp_nan_d   = tail.nan;
`else
    resp_ge_d    = cmp_ge;
`endif
  end

  // Operand, pointer, tag pipeline and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp_a_q      <= '0;
      cmp_b_q      <= '0;
      ptr_q        <= '0;
      for (int unsigned k = 0; k <= CMP_LAT; k++) tag_q[k] <= '0;
      resp_valid_q <= '0;
      resp_id_q    <= '0;
      resp_ge_q    <= 1'b0;
`ifdef FPCMP_SCHED_NAN_EN
      resp_nan_q   <= 1'b0;
`endif
    end else begin
      cmp_a_q      <= cmp_a_d;
      cmp_b_q      <= cmp_b_d;
      ptr_q        <= ptr_d;
      tag_q[0]     <= tag_d;
      for (int unsigned k = 1; k <= CMP_LAT; k++) tag_q[k] <= tag_q[k-1];
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_ge_q    <= resp_ge_d;
`ifdef FPCMP_SCHED_NAN_EN
      resp_nan_q   <= resp_nan_d;
`endif
    end
  end

  // Idle when no tag or result is outstanding
  always_comb begin
    busy = |resp_valid_q;
    for (int unsigned k = 0; k <= CMP_LAT; k++) busy = busy | tag_q[k].valid;
  end

  assign idle       = ~busy;
  assign cmp_a      = cmp_a_q;
  assign cmp_b      = cmp_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_ge    = resp_ge_q;
`ifdef FPCMP_SCHED_NAN_EN
  assign resp_nan   = resp_nan_q;
`endif

endmodule
